// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, sequencer state type and pixel level-shift helper
package dct_pkg;
  localparam int ROWS_PER_BLK = 8;
  localparam int PIX_W = 8;
  localparam int COEF_W = 12;
  localparam int LEVEL_SHIFT = 128;
  localparam int ROW_W = ROWS_PER_BLK * PIX_W;
  typedef enum logic [1:0] {IDLE, FEED, GAP} seq_state_t;
  function automatic logic [ROW_W-1:0] level_shift(input logic [ROW_W-1:0] p);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < ROWS_PER_BLK; k++)
      r[k*PIX_W +: PIX_W] = PIX_W'({1'b0, p[k*PIX_W +: PIX_W]} - (PIX_W+1)'(LEVEL_SHIFT));
    return r;
  endfunction
endpackage

// File: rtl/dct_credit_ctr.sv
// dct_credit_ctr: in-flight block credits, underflow flag and retired-block counter
module dct_credit_ctr
  import dct_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [2:0]       o_inflight,
  output logic [CNT_W-1:0] o_block_cnt,
  output logic             o_err_underflow
);
  logic [2:0] r_inflight;
  logic [CNT_W-1:0] r_cnt;
  logic r_err;
  logic w_under;
  logic [2:0] w_next;
  assign w_under = i_dec && r_inflight == 3'd0;
  assign w_next = (i_inc && !i_dec && r_inflight != 3'd7) ? r_inflight + 3'd1 :
                  (i_dec && !i_inc && !w_under) ? r_inflight - 3'd1 : r_inflight;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_inflight <= w_next;
      r_cnt <= r_cnt + CNT_W'(i_dec);
      r_err <= r_err | w_under;
    end
  end
  assign o_inflight = r_inflight;
  assign o_block_cnt = r_cnt;
  assign o_err_underflow = r_err;
endmodule

// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer: feeds level-shifted 8-row blocks to the DCT with gaps and credit limiting
module dct_block_sequencer
  import dct_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  input  logic [63:0]      i_pix,
  output logic             o_dct_valid,
  output logic [63:0]      o_dct_row,
  input  logic             i_dct_done,
  output logic [2:0]       o_inflight,
  output logic [CNT_W-1:0] o_block_cnt,
  output logic             o_busy,
  output logic             o_err_underflow
);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  seq_state_t r_state;
  seq_state_t w_next;
  logic [2:0] r_row;
  logic [GW-1:0] r_gap;
  logic r_valid;
  logic [63:0] r_row_out;
  logic w_hs, w_first, w_last, w_gap_end;
  logic [2:0] w_inflight;
  assign o_pix_ready = r_state == FEED;
  assign w_hs = i_pix_valid & o_pix_ready;
  assign w_first = w_hs && r_row == 3'd0;
  assign w_last = w_hs && r_row == 3'd7;
  assign w_gap_end = r_gap == GW'(GAP_CYCLES - 1);
  assign w_next = (r_state == IDLE) ? ((i_enable && w_inflight < 3'(MAX_INFLIGHT)) ? FEED : IDLE) :
                  (r_state == FEED) ? (w_last ? (GAP_CYCLES == 0 ? IDLE : GAP) : FEED) :
                  (w_gap_end ? IDLE : GAP);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_row <= '0;
      r_gap <= '0;
      r_valid <= 1'b0;
      r_row_out <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_hs;
      r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
      if (w_hs) begin
        r_row <= r_row + 3'd1;
        r_row_out <= level_shift(i_pix);
      end
    end
  end
  dct_credit_ctr #(.CNT_W(CNT_W)) u_credit (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_inc          (w_first),
    .i_dec          (i_dct_done),
    .o_inflight     (w_inflight),
    .o_block_cnt    (o_block_cnt),
    .o_err_underflow(o_err_underflow)
  );
  assign o_inflight = w_inflight;
  assign o_dct_valid = r_valid;
  assign o_dct_row = r_row_out;
  assign o_busy = r_state != IDLE || w_inflight != 3'd0;
endmodule
